// File: rtl/alu_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : alu_rr_scheduler
// Purpose  : Shares a single ALU between two requesters. Round-robin
//            arbitration with one operation in flight. Operands and opcode
//            are driven to the ALU from registers, and the result is captured
//            after ALU_LAT cycles. Valid/ready handshakes are used on both
//            the request and response sides.
// Revision : 1.0 - initial release
// ============================================================================
module alu_rr_scheduler #(
    parameter int DATA_W  = 8,
    parameter int SEL_W   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    // requester 0
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [SEL_W-1:0]  req0_sel,
    // requester 1
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [SEL_W-1:0]  req1_sel,
    // ALU side
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W:0]   alu_result,
    // response side
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W:0]   rsp_result,
    output logic              busy
);

    // Counter only needs to hold ALU_LAT-1; keep at least one bit.
    localparam int              c_CNT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(ALU_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_rr_ptr;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]    r_alu_a;
    logic [DATA_W-1:0]    r_alu_b;
    logic [SEL_W-1:0]     r_alu_sel;
    logic                 r_rsp_valid;
    logic                 r_rsp_id;
    logic [DATA_W:0]      r_rsp_result;

    logic                 w_grant0;
    logic                 w_grant1;
    logic                 w_req_fire;
    logic                 w_exec_done;
    logic                 w_rsp_fire;

    // Arbitration: a lone requester always wins; on contention rr_ptr picks.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant0 = ~r_rr_ptr;
            w_grant1 = r_rr_ptr;
        end else begin
            w_grant0 = req0_valid;
            w_grant1 = req1_valid;
        end
    end

    // Ready is withheld while reset is asserted so no request looks accepted.
    assign req0_ready  = rst_n & (r_state == S_IDLE) & w_grant0;
    assign req1_ready  = rst_n & (r_state == S_IDLE) & w_grant1;
    assign w_req_fire  = req0_ready | req1_ready;
    assign w_exec_done = (r_state == S_EXEC) && (r_cnt == '0);
    assign w_rsp_fire  = (r_state == S_RESP) && rsp_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: IDLE -> EXEC -> RESP -> IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_req_fire)  w_state_next = S_EXEC;
            S_EXEC: if (w_exec_done) w_state_next = S_RESP;
            S_RESP: if (rsp_ready)   w_state_next = S_IDLE;
            default:                 w_state_next = S_IDLE;
        endcase
    end

    // Datapath: latch accepted op, count ALU latency, capture and hand off result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_sel    <= '0;
            r_cnt        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rr_ptr     <= 1'b0;
        end else begin
            if (w_req_fire) begin
                r_alu_a   <= req1_ready ? req1_a   : req0_a;
                r_alu_b   <= req1_ready ? req1_b   : req0_b;
                r_alu_sel <= req1_ready ? req1_sel : req0_sel;
                r_rsp_id  <= req1_ready;
                r_cnt     <= c_CNT_LOAD;
            end
            if (r_state == S_EXEC) begin
                if (w_exec_done) begin
                    r_rsp_result <= alu_result;
                    r_rsp_valid  <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - c_CNT_W'(1);
                end
            end
            // Next contention goes to the requester that was not just served.
            if (w_rsp_fire) begin
                r_rsp_valid <= 1'b0;
                r_rr_ptr    <= ~r_rsp_id;
            end
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_sel    = r_alu_sel;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_rr_scheduler
// Purpose  : Directed bench for alu_rr_scheduler with a scoreboard queue per
//            DUT; a behavioural ALU sits on each DUT's ALU port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_rr_scheduler;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT 1 (ALU_LAT = 1) ----------------
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b;
    logic [3:0] req0_sel, req1_sel, alu_sel;
    logic [8:0] alu_result, rsp_result;
    logic       rsp_valid, rsp_ready, rsp_id, busy;

    // ---------------- DUT 2 (ALU_LAT = 3) ----------------
    logic       d2_req0_valid, d2_req0_ready, d2_req1_valid, d2_req1_ready;
    logic [7:0] d2_req0_a, d2_req0_b, d2_req1_a, d2_req1_b, d2_alu_a, d2_alu_b;
    logic [3:0] d2_req0_sel, d2_req1_sel, d2_alu_sel;
    logic [8:0] d2_alu_result, d2_rsp_result;
    logic       d2_rsp_valid, d2_rsp_ready, d2_rsp_id, d2_busy;

    logic [9:0] q1[$];   // {id, result} expected from DUT 1
    logic [9:0] q2[$];   // {id, result} expected from DUT 2

    function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [3:0] s);
        case (s)
            4'd0:    return {1'b0, a} + {1'b0, b};
            4'd1:    return {1'b0, a} - {1'b0, b};
            4'd2:    return {1'b0, a & b};
            4'd3:    return {1'b0, a | b};
            default: return 9'd0;
        endcase
    endfunction

    assign alu_result    = alu_model(alu_a, alu_b, alu_sel);
    assign d2_alu_result = alu_model(d2_alu_a, d2_alu_b, d2_alu_sel);

    alu_rr_scheduler #(.DATA_W(8), .SEL_W(4), .ALU_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result), .busy(busy)
    );

    alu_rr_scheduler #(.DATA_W(8), .SEL_W(4), .ALU_LAT(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(d2_req0_valid), .req0_ready(d2_req0_ready), .req0_a(d2_req0_a), .req0_b(d2_req0_b), .req0_sel(d2_req0_sel),
        .req1_valid(d2_req1_valid), .req1_ready(d2_req1_ready), .req1_a(d2_req1_a), .req1_b(d2_req1_b), .req1_sel(d2_req1_sel),
        .alu_a(d2_alu_a), .alu_b(d2_alu_b), .alu_sel(d2_alu_sel), .alu_result(d2_alu_result),
        .rsp_valid(d2_rsp_valid), .rsp_ready(d2_rsp_ready), .rsp_id(d2_rsp_id), .rsp_result(d2_rsp_result), .busy(d2_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Scoreboard monitors: pop one expected entry per response handshake.
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut1_unexpected_rsp actual_id=%0d actual_result=%0d expected=none", rsp_id, rsp_result);
            end else begin
                logic [9:0] e;
                e = q1.pop_front();
                check("dut1_rsp_id", 32'(rsp_id), 32'(e[9]));
                check("dut1_rsp_result", 32'(rsp_result), 32'(e[8:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (d2_rsp_valid && d2_rsp_ready) begin
            if (q2.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut2_unexpected_rsp actual_id=%0d actual_result=%0d expected=none", d2_rsp_id, d2_rsp_result);
            end else begin
                logic [9:0] e;
                e = q2.pop_front();
                check("dut2_rsp_id", 32'(d2_rsp_id), 32'(e[9]));
                check("dut2_rsp_result", 32'(d2_rsp_result), 32'(e[8:0]));
            end
        end
    end

    // Wait (bounded) for a DUT 1 grant; who = granted id, or -1 on timeout.
    task automatic wait_grant(output int who);
        int n;
        n = 0;
        who = -1;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (req0_ready || req1_ready) begin
                who = req1_ready ? 1 : 0;
                break;
            end
        end
        if (who < 0) check("grant_timeout", 32'd0, 32'd1);
    endtask

    // Count negedges after an accept edge until DUT 1 rsp_valid (bounded).
    task automatic wait_rsp(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 50);
    endtask

    // One op from a single requester with rsp_ready high; checks grant and latency.
    task automatic do_single(input bit id, input logic [7:0] a, input logic [7:0] b,
                             input logic [3:0] s, input logic [8:0] exp);
        int who, n;
        @(posedge clk); #1;
        if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_sel = s; end
        else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_sel = s; end
        q1.push_back({id, exp});
        wait_grant(who);
        check("single_grant", 32'(who), 32'(id));
        @(posedge clk); #1;
        req0_valid = 0;
        req1_valid = 0;
        wait_rsp(n);
        check("single_latency", 32'(n), 32'd2);
        check("single_alu_a_held", 32'(alu_a), 32'(a));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int who, n, gid[4], gcyc[4], g;
        logic [8:0] held_res;

        rst_n = 0;
        req0_valid = 1; req0_a = 8'd1; req0_b = 8'd1; req0_sel = 4'd0;
        req1_valid = 1; req1_a = 8'd2; req1_b = 8'd2; req1_sel = 4'd0;
        rsp_ready = 1;
        d2_req0_valid = 1; d2_req0_a = 8'd0; d2_req0_b = 8'd0; d2_req0_sel = 4'd0;
        d2_req1_valid = 1; d2_req1_a = 8'd0; d2_req1_b = 8'd0; d2_req1_sel = 4'd0;
        d2_rsp_ready = 1;

        // 1: reset with both requesters valid
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_req0_ready", 32'(req0_ready), 32'd0);
            check("rst_req1_ready", 32'(req1_ready), 32'd0);
            check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_alu", {alu_a, alu_b, 12'(alu_sel)}, 32'd0);
            check("rst_d2_ready", 32'({d2_req0_ready, d2_req1_ready}), 32'd0);
            check("rst_d2_alu", {d2_alu_a, d2_alu_b, 12'(d2_alu_sel)}, 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1;
        req0_valid = 0; req1_valid = 0;
        d2_req0_valid = 0; d2_req1_valid = 0;

        // 2: single ops; 240+15=255, 0xF0&0x3C=48, 10-3=7 (last one leaves rr_ptr=0)
        do_single(1'b0, 8'd240, 8'd15, 4'd0, 9'd255);
        do_single(1'b0, 8'hF0, 8'h3C, 4'd2, 9'd48);
        do_single(1'b1, 8'd10, 8'd3, 4'd1, 9'd7);

        // 3: continuous double request alternates, one op per 3 cycles
        @(posedge clk); #1;
        req0_valid = 1; req0_a = 8'd255; req0_b = 8'd255; req0_sel = 4'd0;
        req1_valid = 1; req1_a = 8'd1;   req1_b = 8'd2;   req1_sel = 4'd0;
        q1.push_back({1'b0, 9'd510});
        q1.push_back({1'b1, 9'd3});
        q1.push_back({1'b0, 9'd510});
        q1.push_back({1'b1, 9'd3});
        g = 0;
        n = 0;
        while (g < 4 && n < 60) begin
            @(negedge clk);
            n++;
            if (req0_ready || req1_ready) begin
                check("t3_onehot", 32'(req0_ready & req1_ready), 32'd0);
                gid[g] = req1_ready ? 1 : 0;
                gcyc[g] = cyc;
                g++;
            end
        end
        check("t3_grant_count", 32'(g), 32'd4);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        if (g == 4) begin
            for (int i = 0; i < 4; i++) check("t3_grant_order", 32'(gid[i]), 32'(i % 2));
            for (int i = 1; i < 4; i++) check("t3_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
        end
        wait_rsp(n);
        @(posedge clk); #1;

        // 4: response back-pressure; 10+20=30 granted to req0 (rr_ptr=0)
        rsp_ready = 0;
        req0_valid = 1; req0_a = 8'd10; req0_b = 8'd20; req0_sel = 4'd0;
        req1_valid = 1; req1_a = 8'd1;  req1_b = 8'd1;  req1_sel = 4'd0;
        q1.push_back({1'b0, 9'd30});
        wait_grant(who);
        check("t4_grant", 32'(who), 32'd0);
        @(posedge clk); #1;
        req0_valid = 0;
        wait_rsp(n);
        check("t4_latency", 32'(n), 32'd2);
        held_res = rsp_result;
        check("t4_result_seen", 32'(held_res), 32'd30);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_valid", 32'(rsp_valid), 32'd1);
            check("t4_hold_id", 32'(rsp_id), 32'd0);
            check("t4_hold_result", 32'(rsp_result), 32'(held_res));
            check("t4_hold_ready", 32'({req0_ready, req1_ready}), 32'd0);
            check("t4_hold_busy", 32'(busy), 32'd1);
        end
        @(posedge clk); #1;
        rsp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        check("t4_idle_busy", 32'(busy), 32'd0);
        check("t4_idle_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t4_idle_req1_ready", 32'(req1_ready), 32'd1);
        #1;
        req1_valid = 0;

        // 5: reset during EXEC discards op; then dual request goes to req0
        @(posedge clk); #1;
        req0_valid = 1; req0_a = 8'd3; req0_b = 8'd4; req0_sel = 4'd0;
        wait_grant(who);
        check("t5_single_wins", 32'(who), 32'd0);
        @(posedge clk); #1;
        req0_valid = 0;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_no_rsp", 32'(rsp_valid), 32'd0);
            check("t5_busy", 32'(busy), 32'd0);
            check("t5_alu_a", 32'(alu_a), 32'd0);
        end
        @(posedge clk); #1;
        req0_valid = 1; req0_a = 8'd5;   req0_b = 8'd6;   req0_sel = 4'd0;
        req1_valid = 1; req1_a = 8'd100; req1_b = 8'd100; req1_sel = 4'd0;
        q1.push_back({1'b0, 9'd11});
        wait_grant(who);
        check("t5_grant_after_rst", 32'(who), 32'd0);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        wait_rsp(n);
        check("t5_latency", 32'(n), 32'd2);
        @(posedge clk); #1;

        // 6: ALU_LAT=3 instance, req1 8+7=15
        d2_req1_valid = 1; d2_req1_a = 8'd8; d2_req1_b = 8'd7; d2_req1_sel = 4'd0;
        q2.push_back({1'b1, 9'd15});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!d2_req1_ready && n < 50);
        check("t6_grant", 32'(d2_req1_ready), 32'd1);
        @(posedge clk); #1;
        d2_req1_valid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_alu_a_held", 32'(d2_alu_a), 32'd8);
            check("t6_alu_b_held", 32'(d2_alu_b), 32'd7);
            check("t6_no_rsp_yet", 32'(d2_rsp_valid), 32'd0);
            check("t6_busy", 32'(d2_busy), 32'd1);
        end
        @(negedge clk);
        check("t6_rsp_valid", 32'(d2_rsp_valid), 32'd1);
        check("t6_rsp_result", 32'(d2_rsp_result), 32'd15);

        // drain
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("dut1_queue_empty", 32'(q1.size()), 32'd0);
        check("dut2_queue_empty", 32'(q2.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
